// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus bundle.
// Groups the program-counter throttle, the instruction-memory request/response
// channel and the decode valid/ready channel.
//   master : the fetch queue (drives pc_en, imem_req/addr, dec_valid/pc/instr)
//   slave  : the surroundings (drive pc, flush, imem_gnt/rvalid/rdata, dec_ready)
interface instr_fetch_queue_if;
    logic [31:0] pc;
    logic        pc_en;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;

    modport master (
        input  pc, flush, imem_gnt, imem_rvalid, imem_rdata, dec_ready,
        output pc_en, imem_req, imem_addr, dec_valid, dec_pc, dec_instr
    );

    modport slave (
        output pc, flush, imem_gnt, imem_rvalid, imem_rdata, dec_ready,
        input  pc_en, imem_req, imem_addr, dec_valid, dec_pc, dec_instr
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue.
// Turns the current PC into an instruction-memory request every cycle it has
// room, tags each request with its PC, collects the in-order responses into a
// DEPTH-entry queue and hands {pc, instr} pairs to decode. A redirect (flush)
// empties the queue and counts the still-outstanding responses so they are
// dropped when they come back.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - fetch queue bundle (master side): pc/pc_en/flush, imem_*, dec_*
module instr_fetch_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_fetch_queue_if.master   bus
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned PtrW = IdxW + 1;

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [IdxW-1:0] idx_t;

    localparam ptr_t           PtrOne   = ptr_t'(1);
    localparam logic [PtrW:0]  DepthCnt = (PtrW + 1)'(DEPTH);

    // Pointers carry a wrap bit: head..fill are filled, fill..tail are in flight.
    ptr_t head_q, head_d;
    ptr_t fill_q, fill_d;
    ptr_t tail_q, tail_d;
    // Responses still owed by memory for fetches dropped by a flush.
    ptr_t discard_q, discard_d;

    logic [31:0]      slot_pc_q    [DEPTH];
    logic [31:0]      slot_instr_q [DEPTH];
    logic [DEPTH-1:0] slot_filled_q;

    idx_t head_idx, fill_idx, tail_idx;
    ptr_t in_flight;
    logic [PtrW:0] in_use;
    logic issue, resp_drop, resp_fill, deq;

    assign head_idx = head_q[IdxW-1:0];
    assign fill_idx = fill_q[IdxW-1:0];
    assign tail_idx = tail_q[IdxW-1:0];

    always_comb begin
        in_flight = tail_q - fill_q;
        // Dropped-but-outstanding fetches still occupy memory capacity.
        in_use    = {1'b0, tail_q - head_q} + {1'b0, discard_q};

        bus.imem_req  = !rst && !bus.flush && (in_use < DepthCnt);
        bus.imem_addr = {bus.pc[31:2], 2'b00};
        issue         = bus.imem_req && bus.imem_gnt;
        bus.pc_en     = issue;

        bus.dec_valid = slot_filled_q[head_idx] && (head_q != fill_q) && !bus.flush;
        bus.dec_pc    = slot_pc_q[head_idx];
        bus.dec_instr = slot_instr_q[head_idx];
        deq           = bus.dec_valid && bus.dec_ready;

        resp_drop = !bus.flush && bus.imem_rvalid && (discard_q != '0);
        resp_fill = !bus.flush && bus.imem_rvalid && (discard_q == '0) && (fill_q != tail_q);
    end

    always_comb begin
        head_d    = head_q;
        fill_d    = fill_q;
        tail_d    = tail_q;
        discard_d = discard_q;
        if (bus.flush) begin
            head_d    = tail_q;
            fill_d    = tail_q;
            discard_d = discard_q + in_flight;
            // A response arriving in the flush cycle is one of those owed.
            if (bus.imem_rvalid && (discard_d != '0)) begin
                discard_d = discard_d - PtrOne;
            end
        end else begin
            if (issue) begin
                tail_d = tail_q + PtrOne;
            end
            if (resp_drop) begin
                discard_d = discard_q - PtrOne;
            end
            if (resp_fill) begin
                fill_d = fill_q + PtrOne;
            end
            if (deq) begin
                head_d = head_q + PtrOne;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q    <= '0;
            fill_q    <= '0;
            tail_q    <= '0;
            discard_q <= '0;
        end else begin
            head_q    <= head_d;
            fill_q    <= fill_d;
            tail_q    <= tail_d;
            discard_q <= discard_d;
        end
    end

    // Issue, fill and dequeue never target the same slot in one cycle: each
    // collision case implies an empty or full region that disables one side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_pc_q[i]    <= '0;
                slot_instr_q[i] <= '0;
            end
            slot_filled_q <= '0;
        end else if (bus.flush) begin
            slot_filled_q <= '0;
        end else begin
            if (issue) begin
                slot_pc_q[tail_idx]     <= bus.pc;
                slot_filled_q[tail_idx] <= 1'b0;
            end
            if (resp_fill) begin
                slot_instr_q[fill_idx]  <= bus.imem_rdata;
                slot_filled_q[fill_idx] <= 1'b1;
            end
            if (deq) begin
                slot_filled_q[head_idx] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue (DEPTH = 4).
// A bench program counter and an in-order memory model (configurable latency,
// data = addr ^ 0xA5A5_0000) surround the DUT. Directed scenarios push the
// expected decode pairs into a scoreboard; a monitor pops and compares on
// every decode handshake. Direct checks cover reset, throttling and flush.
module tb_instr_fetch_queue;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instr_fetch_queue_if ifc ();

    instr_fetch_queue #(
        .DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_pop  = 0;
    int cyc    = 0;
    int lat    = 1;

    logic [31:0] pc_nxt       = 32'h0;
    logic [31:0] flush_target = 32'h0;

    logic [31:0] exp_pc    [$];
    logic [31:0] exp_instr [$];
    logic [31:0] mq_addr   [$];
    int          mq_due    [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_pair(input logic [31:0] p, input logic [31:0] ins);
        exp_pc.push_back(p);
        exp_instr.push_back(ins);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Bench program counter: next value decided mid-cycle, applied after the edge.
    initial begin
        ifc.pc = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            ifc.pc = pc_nxt;
        end
    end

    // In-order instruction memory; in-flight responses vanish on reset.
    initial begin
        ifc.imem_rvalid = 1'b0;
        ifc.imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                mq_addr.delete();
                mq_due.delete();
                ifc.imem_rvalid = 1'b0;
                pc_nxt = ifc.pc;
            end else begin
                if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
                    ifc.imem_rvalid = 1'b1;
                    ifc.imem_rdata  = mq_addr.pop_front() ^ 32'hA5A5_0000;
                    void'(mq_due.pop_front());
                end else begin
                    ifc.imem_rvalid = 1'b0;
                    ifc.imem_rdata  = 32'h0BAD_0BAD;
                end
                if (ifc.imem_req && ifc.imem_gnt) begin
                    mq_addr.push_back(ifc.imem_addr);
                    mq_due.push_back(cyc + lat);
                end
                pc_nxt = ifc.flush ? flush_target : (ifc.pc_en ? ifc.pc + 32'd4 : ifc.pc);
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        logic [31:0] e_pc, e_in;
        forever begin
            @(negedge clk);
            if (ifc.flush && !rst) begin
                checks++;
                if (ifc.dec_valid) begin
                    errors++;
                    $display("FAIL flush_gate: dec_valid=1 during flush, required 0 (t=%0t)", $time);
                end
            end
            if (ifc.dec_valid && ifc.dec_ready) begin
                checks++;
                if (exp_pc.size() == 0) begin
                    errors++;
                    $display("FAIL dec_unexpected: got pc=0x%08h instr=0x%08h, required none (t=%0t)",
                             ifc.dec_pc, ifc.dec_instr, $time);
                end else begin
                    e_pc = exp_pc.pop_front();
                    e_in = exp_instr.pop_front();
                    if (ifc.dec_pc !== e_pc || ifc.dec_instr !== e_in) begin
                        errors++;
                        $display("FAIL dec_pair: got (0x%08h,0x%08h), required (0x%08h,0x%08h) (t=%0t)",
                                 ifc.dec_pc, ifc.dec_instr, e_pc, e_in, $time);
                    end
                end
                n_pop++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        ifc.flush     = 1'b0;
        ifc.imem_gnt  = 1'b0;
        ifc.dec_ready = 1'b0;

        // Reset state, mid-cycle while reset is held.
        #12;
        check("rst_imem_req", 32'(ifc.imem_req), 32'h0);
        check("rst_pc_en", 32'(ifc.pc_en), 32'h0);
        check("rst_dec_valid", 32'(ifc.dec_valid), 32'h0);
        check("rst_dec_pc", ifc.dec_pc, 32'h0);
        check("rst_dec_instr", ifc.dec_instr, 32'h0);
        step();

        // Streaming, 1-cycle memory: first pair at cycle 2, then one per cycle.
        ifc.imem_gnt  = 1'b1;
        ifc.dec_ready = 1'b1;
        lat = 1;
        push_pair(32'h0000_0000, 32'hA5A5_0000);
        push_pair(32'h0000_0004, 32'hA5A5_0004);
        push_pair(32'h0000_0008, 32'hA5A5_0008);
        push_pair(32'h0000_000C, 32'hA5A5_000C);
        push_pair(32'h0000_0010, 32'hA5A5_0010);
        push_pair(32'h0000_0014, 32'hA5A5_0014);
        push_pair(32'h0000_0018, 32'hA5A5_0018);
        push_pair(32'h0000_001C, 32'hA5A5_001C);
        base = n_pop;
        rst  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 6) check("stream_rate", 32'(n_pop - base), 32'd4);
            at_neg();
            check("stream_pc_en", 32'(ifc.pc_en), 32'h1);
            step();
        end

        // Grant stall: request held with a stable address, PC frozen.
        ifc.imem_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            at_neg();
            check("stall_req", 32'(ifc.imem_req), 32'h1);
            check("stall_addr", ifc.imem_addr, 32'h0000_0020);
            check("stall_pc_en", 32'(ifc.pc_en), 32'h0);
            step();
        end
        check("stream_count", 32'(n_pop - base), 32'd8);

        // Redirect to 0x0 with an empty queue.
        ifc.flush     = 1'b1;
        flush_target  = 32'h0;
        ifc.imem_gnt  = 1'b1;
        ifc.dec_ready = 1'b0;
        at_neg();
        check("flush_req", 32'(ifc.imem_req), 32'h0);
        check("flush_pc_en", 32'(ifc.pc_en), 32'h0);
        step();
        ifc.flush = 1'b0;

        // Backpressure: exactly four issues, then the queue is full.
        push_pair(32'h0000_0000, 32'hA5A5_0000);
        push_pair(32'h0000_0004, 32'hA5A5_0004);
        push_pair(32'h0000_0008, 32'hA5A5_0008);
        push_pair(32'h0000_000C, 32'hA5A5_000C);
        push_pair(32'h0000_0010, 32'hA5A5_0010);
        base = n_pop;
        repeat (4) step();
        for (int k = 0; k < 2; k++) begin
            at_neg();
            check("bp_req", 32'(ifc.imem_req), 32'h0);
            check("bp_pc_en", 32'(ifc.pc_en), 32'h0);
            check("bp_addr", ifc.imem_addr, 32'h0000_0010);
            check("bp_head_valid", 32'(ifc.dec_valid), 32'h1);
            check("bp_head_pc", ifc.dec_pc, 32'h0000_0000);
            step();
        end
        check("bp_hold", 32'(n_pop - base), 32'd0);
        ifc.dec_ready = 1'b1;
        at_neg();
        check("bp_still_full", 32'(ifc.imem_req), 32'h0);
        step();
        at_neg();
        check("bp_resume_req", 32'(ifc.imem_req), 32'h1);
        check("bp_resume_addr", ifc.imem_addr, 32'h0000_0010);
        step();
        ifc.imem_gnt = 1'b0;
        repeat (4) step();
        check("bp_count", 32'(n_pop - base), 32'd5);

        // Flush with two fetches in flight on a 3-cycle memory.
        lat = 3;
        ifc.imem_gnt = 1'b1;
        push_pair(32'h0000_0100, 32'hA5A5_0100);
        push_pair(32'h0000_0104, 32'hA5A5_0104);
        base = n_pop;
        step();
        step();
        ifc.flush    = 1'b1;
        flush_target = 32'h0000_0100;
        at_neg();
        check("fl2_valid", 32'(ifc.dec_valid), 32'h0);
        step();
        ifc.flush = 1'b0;
        for (int k = 3; k < 7; k++) begin
            if (k == 5) ifc.imem_gnt = 1'b0;
            at_neg();
            check("fl2_stale", 32'(ifc.dec_valid), 32'h0);
            step();
        end
        at_neg();
        check("fl2_first_valid", 32'(ifc.dec_valid), 32'h1);
        check("fl2_first_pc", ifc.dec_pc, 32'h0000_0100);
        step();
        repeat (2) step();
        check("fl2_count", 32'(n_pop - base), 32'd2);

        // Flush in the same cycle as a response, with a filled head and ready=1.
        lat = 2;
        ifc.imem_gnt  = 1'b1;
        ifc.dec_ready = 1'b0;
        push_pair(32'h0000_0200, 32'hA5A5_0200);
        base = n_pop;
        repeat (3) step();
        ifc.imem_gnt  = 1'b0;
        ifc.dec_ready = 1'b1;
        ifc.flush     = 1'b1;
        flush_target  = 32'h0000_0200;
        at_neg();
        check("flrv_valid", 32'(ifc.dec_valid), 32'h0);
        step();
        ifc.flush    = 1'b0;
        ifc.imem_gnt = 1'b1;
        at_neg();
        check("flrv_addr", ifc.imem_addr, 32'h0000_0200);
        check("flrv_empty4", 32'(ifc.dec_valid), 32'h0);
        step();
        ifc.imem_gnt = 1'b0;
        for (int k = 0; k < 2; k++) begin
            at_neg();
            check("flrv_empty", 32'(ifc.dec_valid), 32'h0);
            step();
        end
        at_neg();
        check("flrv_instr", ifc.dec_instr, 32'hA5A5_0200);
        step();
        check("flrv_count", 32'(n_pop - base), 32'd1);

        // Asynchronous reset in the middle of a stream.
        lat = 1;
        ifc.imem_gnt = 1'b1;
        push_pair(32'h0000_0204, 32'hA5A5_0204);
        base = n_pop;
        repeat (3) step();
        check("ar_pre_valid", 32'(ifc.dec_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_dec_valid", 32'(ifc.dec_valid), 32'h0);
        check("ar_imem_req", 32'(ifc.imem_req), 32'h0);
        check("ar_pc_en", 32'(ifc.pc_en), 32'h0);
        step();
        step();
        push_pair(32'h0000_0210, 32'hA5A5_0210);
        push_pair(32'h0000_0214, 32'hA5A5_0214);
        rst = 1'b0;
        at_neg();
        check("ar_restart_addr", ifc.imem_addr, 32'h0000_0210);
        check("ar_restart_empty", 32'(ifc.dec_valid), 32'h0);
        step();
        step();
        ifc.imem_gnt = 1'b0;
        repeat (3) step();
        check("ar_count", 32'(n_pop - base), 32'd3);

        check("final_empty", 32'(exp_pc.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Fetch-side consumer of the program counter. Each cycle it turns the current PC into an instruction-memory request and tags the request with that PC. It collects in-order memory responses into a DEPTH-entry queue and presents {pc, instruction} pairs to decode with a valid/ready handshake. It throttles the program counter through its enable and drops all queued and in-flight fetches on a redirect.

## Interface
- DEPTH, 4, queue entries and the maximum number of issued-but-not-consumed fetches; power of two, ≥2
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pc  in  32  current fetch PC from the program counter
- pc_en  out  1  advance enable to the program counter; external PC enable = pc_en | flush
- flush  in  1  redirect: PC loads a new target at this edge; drop everything
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, {pc[31:2], 2'b00}
- imem_gnt  in  1  request accepted this cycle (imem_req & imem_gnt = issue)
- imem_rvalid  in  1  response valid; responses return in issue order, ≥1 cycle after issue
- imem_rdata  in  32  response instruction word
- dec_valid  out  1  head entry holds a fetched instruction
- dec_ready  in  1  decode accepts head this cycle
- dec_pc  out  32  PC of head entry
- dec_instr  out  32  instruction of head entry

## Operation
- Queue: DEPTH slots, each {pc, instr, filled}. Three pointers (head, fill, tail), each log2(DEPTH)+1 bits with wrap bit.
- Issue: imem_req = !rst & !flush & (tail−head) + discard < DEPTH. imem_req never depends on imem_gnt. On issue, slot[tail] ← {pc, filled=0}; tail+1. pc_en = imem_req & imem_gnt.
- Response: if imem_rvalid & discard≠0: drop, discard−1. Else if fill≠tail: slot[fill] ← {instr=imem_rdata, filled=1}; fill+1. Otherwise (spurious): ignore.
- Dequeue: dec_valid = slot[head].filled & (head≠fill) & !flush; dec_pc/dec_instr = slot[head] fields. On dec_valid & dec_ready: head+1, slot filled cleared.
- Issue, response and dequeue may all happen in the same cycle. Pointer updates are independent.
- Flush, which has priority over everything: head ← tail ← fill (all equal). discard ← discard + (tail − fill) − (imem_rvalid ? 1 : 0), with the response in the flush cycle dropped. No issue and no dequeue in the flush cycle. All filled bits are cleared.
- A flush while discard≠0 accumulates; discard never exceeds DEPTH (width log2(DEPTH)+1).
- Fetches after a flush use the new PC. Their responses arrive only after the discard count drains, because responses are in order.
- Misaligned pc[1:0] is not checked; the low bits are forced to zero on imem_addr, and dec_pc reports the full pc.

## Timing
- Reset (async assert): pointers 0, discard 0, filled bits 0, slot pc/instr 0. Outputs: imem_req 0, pc_en 0, dec_valid 0, dec_pc 0, dec_instr 0. Deassertion is sampled synchronously; imem_req may rise in the first cycle after.
- Issue in cycle N → PC advances at the N/N+1 edge → next request carries pc+4 in N+1.
- Response in cycle M → dec_valid earliest in M+1. There is no combinational path from imem_rdata to the dec_* outputs.
- With 1-cycle memory latency, gnt=1 and dec_ready=1: one instruction per cycle sustained after a 2-cycle fill.
- Full: (tail−head)+discard = DEPTH → imem_req 0, pc_en 0, PC holds.
- Reset mid-operation: all state is lost. Any responses still in flight after reset are the memory's responsibility and must not be returned.

## Test plan
- Streaming: pc starts 0x0, 1-cycle memory returning addr^0xA5A5_0000, gnt=1, ready=1 → dec pairs (0x0, 0xA5A5_0000), (0x4, 0xA5A5_0004), … on consecutive cycles from cycle 2; pc_en held at 1.
- Backpressure: dec_ready=0 with DEPTH=4 → exactly 4 issues, then imem_req=0 and pc_en=0. Raise ready → 0x0,0x4,0x8,0xC drained in order and issue resumes at 0x10.
- Flush with 2 in flight (3-cycle memory): flush, pc←0x100 → the next 2 responses are dropped and the first dec_pc is 0x100. No stale instruction is ever seen at decode.
- Flush in the same cycle as rvalid and dec_ready=1 → dec_valid 0 that cycle, the response dropped, discard = outstanding−1.
- Grant stall: gnt=0 for 3 cycles with req=1 → imem_addr is stable, pc_en=0, and PC does not move.
- Async reset asserted mid-stream → dec_valid, imem_req and pc_en go 0 without waiting for a clock edge. After release the queue is empty and fetch restarts from the current pc.
